// File: rtl/rambus_arbiter.sv
// Round-robin Wishbone arbiter sharing the single rambus port among NUM_MASTERS requesters.
// A grant is held for the whole cyc; a stall watchdog errors out the granted master and frees the port.
module rambus_arbiter #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                              wb_clk_i,
  input  logic                              wb_rst_n_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [4*NUM_MASTERS-1:0]          m_sel_i,
  input  logic [32*NUM_MASTERS-1:0]         m_dat_i,
  input  logic [ADDR_WIDTH*NUM_MASTERS-1:0] m_adr_i,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [31:0]                       m_dat_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [3:0]                        s_sel_o,
  output logic [31:0]                       s_dat_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  input  logic                              s_ack_i,
  input  logic [31:0]                       s_dat_i,
  output logic [NUM_MASTERS-1:0]            grant_o
);

  localparam int unsigned PTR_W   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned WD_NEED = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned WD_W    = (WD_NEED > 8) ? WD_NEED : 8;

  localparam logic [WD_W-1:0]  WD_MAX  = '1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic             WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic [NUM_MASTERS-1:0] err_q, err_d;

  logic                   g_cyc, g_stb, g_we;
  logic [3:0]             g_sel;
  logic [31:0]            g_dat;
  logic [ADDR_WIDTH-1:0]  g_adr;
  logic                   stall, timeout, found;

  // One-hot mux of the granted master's bus signals
  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_sel = '0;
    g_dat = '0;
    g_adr = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q[k]) begin
        g_cyc = m_cyc_i[k];
        g_stb = m_stb_i[k];
        g_we  = m_we_i[k];
        g_sel = m_sel_i[4*k +: 4];
        g_dat = m_dat_i[32*k +: 32];
        g_adr = m_adr_i[ADDR_WIDTH*k +: ADDR_WIDTH];
      end
    end
  end

  // Slave side is live only in BUSY, so a dropped cyc reaches the slave in the same cycle
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_dat_o = '0;
    s_adr_o = '0;
    m_ack_o = '0;
    if (state_q == ST_BUSY) begin
      s_cyc_o = g_cyc;
      s_stb_o = g_cyc & g_stb;
      s_we_o  = g_we;
      s_sel_o = g_sel;
      s_dat_o = g_dat;
      s_adr_o = g_adr;
      m_ack_o = grant_q & {NUM_MASTERS{s_ack_i}};
    end
  end

  assign m_dat_o = s_dat_i;
  assign grant_o = grant_q;
  assign m_err_o = err_q;

  assign stall   = s_stb_o & ~s_ack_i;
  assign timeout = WD_EN & stall & (wd_q == WD_LAST);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    wd_d    = '0;
    err_d   = '0;
    found   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|m_cyc_i) begin
          // Search above the last grant first, then wrap to the bottom
          for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!found && m_cyc_i[k] && (k > int'(ptr_q))) begin
              found      = 1'b1;
              grant_d    = '0;
              grant_d[k] = 1'b1;
              ptr_d      = PTR_W'(k);
            end
          end
          for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!found && m_cyc_i[k] && (k <= int'(ptr_q))) begin
              found      = 1'b1;
              grant_d    = '0;
              grant_d[k] = 1'b1;
              ptr_d      = PTR_W'(k);
            end
          end
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!g_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else if (timeout) begin
          state_d = ST_HOLD;
          err_d   = grant_q;
        end else if (stall) begin
          wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);
        end
      end
      ST_HOLD: begin
        if (!g_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_RST;
      wd_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

endmodule
